// File: rtl/sensor_hcsr04_emulador.sv
// HC-SR04 responder model: answers a trigger pulse with an echo whose width encodes `distancia` in cm.
// Optional fault injection input `falha` is enabled with the SENSOR_HCSR04_FALHA_EN macro.
`timescale 1ns/1ps
module sensor_hcsr04_emulador #(
  parameter int CICLOS_POR_CM  = 2941,
  parameter int TRIGGER_MIN    = 500,
  parameter int RAJADA_CICLOS  = 10000,
  parameter int TIMEOUT_CICLOS = 1900000,
  parameter int HOLDOFF_CICLOS = 500000,
  parameter int DIST_MIN       = 2,
  parameter int DIST_MAX       = 400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
`ifdef SENSOR_HCSR04_FALHA_EN
  input  logic       falha,
`endif
  output logic       echo,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    ESPERA       = 3'd0,
    TRIGGER_ALTO = 3'd1,
    RAJADA       = 3'd2,
    ECHO         = 3'd3,
    HOLDOFF      = 3'd4
  } estado_t;

  localparam logic [20:0] TRIG_MIN_C = 21'(TRIGGER_MIN);
  localparam logic [20:0] RAJ_ULT    = 21'(RAJADA_CICLOS - 1);
  localparam logic [20:0] TO_ULT     = 21'(TIMEOUT_CICLOS - 1);
  localparam logic [20:0] HOLD_ULT   = 21'(HOLDOFF_CICLOS - 1);
  localparam logic [20:0] CM_ULT     = 21'(CICLOS_POR_CM - 1);
  localparam logic [8:0]  D_MIN      = 9'(DIST_MIN);
  localparam logic [8:0]  D_MAX      = 9'(DIST_MAX);

  function automatic logic [20:0] inc_sat(input logic [20:0] v);
    return (v == '1) ? v : v + 21'd1;
  endfunction

  estado_t     estado, estado_nxt;
  logic        trig_p0, trig_s, trig_d;
  logic        sobe;
  logic [20:0] cnt, cnt_nxt;
  logic [8:0]  cm_cnt, cm_nxt;
  logic [8:0]  dist_r;
  logic        timeout_r;
  logic        captura;
  logic        timeout_cap;
`ifdef SENSOR_HCSR04_FALHA_EN
  logic        falha_r;
`endif

  assign sobe = trig_s & ~trig_d;

  // Out-of-range (or injected-fault) measurements are decided once, at the accept point.
`ifdef SENSOR_HCSR04_FALHA_EN
  assign timeout_cap = falha || (distancia < D_MIN) || (distancia > D_MAX);
`else
  assign timeout_cap = (distancia < D_MIN) || (distancia > D_MAX);
`endif

  always_comb begin
    estado_nxt = estado;
    cnt_nxt    = cnt;
    cm_nxt     = cm_cnt;
    captura    = 1'b0;
    ocupado    = 1'b1;
    db_estado  = 4'b1110;
    case (estado)
      ESPERA: begin
        ocupado   = 1'b0;
        db_estado = 4'b0000;
        if (sobe) begin
          estado_nxt = TRIGGER_ALTO;
          cnt_nxt    = 21'd1;
        end
      end
      TRIGGER_ALTO: begin
        db_estado = 4'b0001;
        if (trig_s) begin
          cnt_nxt = inc_sat(cnt);
        end else if (cnt >= TRIG_MIN_C) begin
          captura    = 1'b1;
          cnt_nxt    = '0;
          cm_nxt     = '0;
          estado_nxt = RAJADA;
        end else begin
          cnt_nxt    = '0;
          estado_nxt = ESPERA;
        end
      end
      RAJADA: begin
        db_estado = 4'b0010;
        if (cnt == RAJ_ULT) begin
          cnt_nxt    = '0;
          cm_nxt     = '0;
          estado_nxt = ECHO;
        end else begin
          cnt_nxt = inc_sat(cnt);
        end
      end
      ECHO: begin
`ifdef SENSOR_HCSR04_FALHA_EN
        db_estado = falha_r ? 4'b1000 : 4'b0011;
`else
        db_estado = 4'b0011;
`endif
        if (timeout_r) begin
          if (cnt == TO_ULT) begin
            cnt_nxt    = '0;
            estado_nxt = HOLDOFF;
          end else begin
            cnt_nxt = inc_sat(cnt);
          end
        end else if (cnt == CM_ULT) begin
          // One full cm elapsed; width = dist_r * CICLOS_POR_CM without a multiplier.
          cnt_nxt = '0;
          if (cm_cnt == dist_r - 9'd1) begin
            cm_nxt     = '0;
            estado_nxt = HOLDOFF;
          end else begin
            cm_nxt = cm_cnt + 9'd1;
          end
        end else begin
          cnt_nxt = inc_sat(cnt);
        end
      end
      HOLDOFF: begin
        db_estado = 4'b0100;
        if (cnt == HOLD_ULT) begin
          cnt_nxt    = '0;
          estado_nxt = ESPERA;
        end else begin
          cnt_nxt = inc_sat(cnt);
        end
      end
      default: begin
        estado_nxt = ESPERA;
        cnt_nxt    = '0;
        cm_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_p0   <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
      estado    <= ESPERA;
      cnt       <= '0;
      cm_cnt    <= '0;
      dist_r    <= '0;
      timeout_r <= 1'b0;
      echo      <= 1'b0;
    end else begin
      trig_p0   <= trigger;
      trig_s    <= trig_p0;
      trig_d    <= trig_s;
      estado    <= estado_nxt;
      cnt       <= cnt_nxt;
      cm_cnt    <= cm_nxt;
      echo      <= (estado_nxt == ECHO);
      if (captura) begin
        dist_r    <= distancia;
        timeout_r <= timeout_cap;
      end
    end
  end

`ifdef SENSOR_HCSR04_FALHA_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      falha_r <= 1'b0;
    end else if (captura) begin
      falha_r <= falha;
    end
  end
`endif

endmodule

// File: tb/tb_sensor_hcsr04_emulador.sv
// Self-checking bench for sensor_hcsr04_emulador: directed and randomized trigger/distance runs
// checked against an arithmetic model of echo latency, width and holdoff.
`timescale 1ns/1ps
module tb_sensor_hcsr04_emulador;

  localparam int CPC  = 4;
  localparam int TMIN = 5;
  localparam int RAJ  = 10;
  localparam int TO   = 2000;
  localparam int HOLD = 20;

  logic       clock;
  logic       reset;
  logic       trigger;
  logic [8:0] distancia;
`ifdef SENSOR_HCSR04_FALHA_EN
  logic       falha;
`endif
  logic       echo;
  logic       ocupado;
  logic [3:0] db_estado;

  int n_cmp  = 0;
  int n_fail = 0;

  sensor_hcsr04_emulador #(
    .CICLOS_POR_CM (CPC),
    .TRIGGER_MIN   (TMIN),
    .RAJADA_CICLOS (RAJ),
    .TIMEOUT_CICLOS(TO),
    .HOLDOFF_CICLOS(HOLD),
    .DIST_MIN      (2),
    .DIST_MAX      (400)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .trigger  (trigger),
    .distancia(distancia),
`ifdef SENSOR_HCSR04_FALHA_EN
    .falha    (falha),
`endif
    .echo     (echo),
    .ocupado  (ocupado),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int model_width(input int d, input bit f);
    if (f) return TO;
    if (d >= 2 && d <= 400) return d * CPC;
    return TO;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_cmp++;
    assert ((obs >= lo && obs <= hi) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic set_falha(input bit f);
`ifdef SENSOR_HCSR04_FALHA_EN
    falha = f;
`else
    if (f) $display("note: falha ignored, feature not built");
`endif
  endtask

  // Full measurement: trigger pulse of `hi` cycles, then latency, width and holdoff checks.
  // With `retrig`, extra trigger activity is injected in RAJADA, ECHO and HOLDOFF; trigger is left high.
  task automatic measure(input string tag, input int hi, input int d, input bit f, input bit retrig);
    int  lat, w, hold, exp_w;
    bit  seen;
    exp_w = model_width(d, f);
    distancia = 9'(d);
    set_falha(f);
    @(posedge clock); #1 trigger = 1'b1;
    repeat (hi) @(posedge clock);
    #1;
    if (hi >= 3) chk({tag, "_st_trig"}, db_estado, 4'b0001);
    trigger = 1'b0;
    seen = 0;
    lat  = 0;
    for (int k = 1; k <= RAJ + 10 && !seen; k++) begin
      @(negedge clock);
      if (k == 5) begin
        chk({tag, "_st_rajada"}, db_estado, 4'b0010);
        distancia = 9'($urandom);
        set_falha(bit'(~f));
      end
      if (retrig && k == 3) trigger = 1'b1;
      if (retrig && k == 8) trigger = 1'b0;
      if (echo) begin
        seen = 1;
        lat  = k;
      end
    end
    chk({tag, "_echo_seen"}, seen, 1);
    if (seen) begin
      chk_rng({tag, "_latency"}, lat, RAJ + 2, RAJ + 4);
      w = 1;
      for (int i = 0; i < TO + 100; i++) begin
        @(negedge clock);
        if (!echo) break;
        w++;
        if (w == exp_w / 2) begin
          chk({tag, "_busy_echo"}, ocupado, 1);
          chk({tag, "_st_echo"}, db_estado, f ? 4'b1000 : 4'b0011);
        end
        if (retrig && w == 10) trigger = 1'b1;
        if (retrig && w == 20) trigger = 1'b0;
      end
      chk({tag, "_width"}, w, exp_w);
      hold = 0;
      for (int i = 0; i < HOLD + 50; i++) begin
        if (!ocupado) break;
        hold++;
        if (hold == 1) chk({tag, "_st_hold"}, db_estado, 4'b0100);
        if (retrig && hold == 5) trigger = 1'b1;
        @(negedge clock);
      end
      chk({tag, "_holdoff"}, hold, HOLD);
      chk({tag, "_st_idle"}, db_estado, 4'b0000);
    end
  endtask

  task automatic expect_reject(input string tag, input int hi);
    int echo_cnt;
    distancia = 9'd30;
    @(posedge clock); #1 trigger = 1'b1;
    repeat (hi) @(posedge clock);
    #1 trigger = 1'b0;
    echo_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (echo) echo_cnt++;
    end
    chk({tag, "_no_echo"}, echo_cnt, 0);
    chk({tag, "_st_idle"}, db_estado, 4'b0000);
    chk({tag, "_idle_busy"}, ocupado, 0);
  endtask

  initial begin
    int d, hi;
    bit seen;
    reset = 1'b0;
    trigger = 1'b0;
    distancia = '0;
    set_falha(1'b0);
    repeat (3) @(negedge clock);
    chk("rst_echo", echo, 0);
    chk("rst_busy", ocupado, 0);
    chk("rst_state", db_estado, 4'b0000);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    measure("basic25", 8, 25, 1'b0, 1'b0);
    expect_reject("glitch3", 3);
    expect_reject("glitch4", 4);
    measure("tmin5", 5, 7, 1'b0, 1'b0);
    measure("d1", 8, 1, 1'b0, 1'b0);
    measure("d450", 8, 450, 1'b0, 1'b0);
    measure("d400", 8, 400, 1'b0, 1'b0);
    measure("d2", 8, 2, 1'b0, 1'b0);
    measure("d0", 8, 0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      d  = int'($urandom_range(0, 511));
      hi = int'($urandom_range(5, 12));
      measure($sformatf("rand%0d", i), hi, d, 1'b0, 1'b0);
    end

    // Re-triggers while busy are ignored; trigger held over the end of HOLDOFF must not start a run.
    measure("retrig", 8, 25, 1'b0, 1'b1);
    repeat (10) @(negedge clock);
    chk("held_no_start", db_estado, 4'b0000);
    trigger = 1'b0;
    repeat (5) @(negedge clock);
    chk("held_released", db_estado, 4'b0000);
    measure("after_held", 8, 25, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an echo.
    distancia = 9'd100;
    @(posedge clock); #1 trigger = 1'b1;
    repeat (8) @(posedge clock);
    #1 trigger = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      if (echo) seen = 1;
    end
    repeat (50) @(negedge clock);
    chk("mid_echo_high", echo, 1);
    reset = 1'b0;
    #1;
    chk("arst_echo", echo, 0);
    chk("arst_state", db_estado, 4'b0000);
    chk("arst_busy", ocupado, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    measure("post_rst", 8, 100, 1'b0, 1'b0);

`ifdef SENSOR_HCSR04_FALHA_EN
    measure("falha1", 8, 25, 1'b1, 1'b0);
    measure("falha0", 8, 25, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
